load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: WORDS, 64, number of 32-bit words in the data memory; byte addresses at or above WORDS*4 are out of range.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  1  CPU presents a load/store request.
REQ-005 SHALL have port: req_ready  output  1  unit idle and able to accept a request.
REQ-006 SHALL have port: req_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, low bits used for SB/SH.
REQ-010 SHALL have port: resp_done  output  1  one-cycle pulse: request complete.
REQ-011 SHALL have port: resp_fault  output  1  valid with resp_done: misaligned, out of range, or illegal funct3.
REQ-012 SHALL have port: resp_rdata  output  32  extended load result, valid with resp_done.
REQ-013 SHALL have port: mem_addr  output  32  word-aligned byte address to data memory.
REQ-014 SHALL have port: mem_wdata  output  32  full word to data memory.
REQ-015 SHALL have port: mem_we  output  1  data memory write enable.
REQ-016 SHALL have port: mem_rdata  input  32  combinational read data from data memory.

Function
REQ-017 SHALL implement FSM states IDLE, RD, WR, RESP, ERR; req_ready = 1 only in IDLE.
REQ-018 SHALL, in IDLE on req_valid at a rising edge, latch store/funct3/addr/wdata and go to: ERR if faulting; RD for loads, SB, SH; WR for SW.
REQ-019 SHALL fault on: funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores; halfword with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= WORDS.
REQ-020 SHALL, in RD, drive mem_addr = {addr[31:2],2'b00}, mem_we = 0, capture mem_rdata into word register at edge, then go to RESP (load) or WR (SB/SH).
REQ-021 SHALL, in WR, assert mem_we = 1 for exactly one cycle with mem_wdata = req_wdata (SW) or captured word with byte lane addr[1:0] / halfword lane addr[1] replaced by req_wdata[7:0] / [15:0] (SB/SH), other lanes unchanged; then go to RESP.
REQ-022 SHALL, in RESP, assert resp_done = 1, resp_fault = 0, resp_rdata = selected lane sign-extended (LB/LH), zero-extended (LBU/LHU), full word (LW), 0 for stores; then go to IDLE.
REQ-023 SHALL, in ERR, assert resp_done = 1, resp_fault = 1, resp_rdata = 0, mem_we = 0; then go to IDLE.
REQ-024 SHALL complete with resp_done in the cycle after: 2 edges past accept for loads and SW, 3 for SB/SH, 1 for faults.
REQ-025 SHALL ignore req_valid outside IDLE; requests held valid are accepted on the first IDLE edge (back-to-back allowed after RESP/ERR).
REQ-026 SHALL drive mem_addr = 0, mem_wdata = 0 in IDLE/RESP/ERR; mem_we = 1 only in WR.
REQ-027 SHALL never write memory for a faulting request.

Reset
REQ-028 SHALL, while rst_n = 0, immediately force state IDLE and outputs req_ready = 1, resp_done = 0, resp_fault = 0, resp_rdata = 0, mem_addr = 0, mem_wdata = 0, mem_we = 0; latched request and word register cleared to 0.
REQ-029 SHALL abort any in-flight request on reset with no subsequent write or resp_done for it.

Verification
REQ-030 SHALL cover: SW 0x10 data 0xDEADBEEF then LW 0x10 -> one mem_we cycle, each resp_done 2 edges after accept, resp_rdata = 0xDEADBEEF.
REQ-031 SHALL cover: word 0x20 = 0x11223344, SB 0x21 data 0xAA -> memory 0x1122AA44, done 3 edges after accept; LB 0x21 -> 0xFFFFFFAA; LBU 0x21 -> 0x000000AA.
REQ-032 SHALL cover: then SH 0x22 data 0x8001 -> memory 0x8001AA44; LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001.
REQ-033 SHALL cover: LW 0x13, SH 0x21, LW 0x100 (WORDS = 64), funct3 011 -> resp_fault = 1, resp_rdata = 0, done 1 edge after accept, mem_we never 1.
REQ-034 SHALL cover: rst_n low during RD of an SB -> mem_we never asserts, memory unchanged, req_ready = 1 after release.
REQ-035 SHALL cover: req_valid held high across two requests -> second accepted only on the edge after resp_done, no request dropped or duplicated.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: aligned word memory port, byte/halfword stores by
// read-modify-write, sign/zero-extended loads, fault reporting.
module load_store_unit #(
    parameter int WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_done,
    output logic        resp_fault,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;

    state_t      state;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;

    function automatic logic is_fault(input logic store, input logic [2:0] f3,
                                      input logic [31:0] addr);
        logic bad_f3;
        logic misaligned;
        if (store)
            bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010});
        else
            bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                     ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        return bad_f3 || misaligned || ({2'b00, addr[31:2]} >= 32'(WORDS));
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                                input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  result = {{24{b[7]}}, b};
            3'b001:  result = {{16{h[15]}}, h};
            3'b010:  result = word;
            3'b100:  result = {24'd0, b};
            3'b101:  result = {16'd0, h};
            default: result = 32'd0;
        endcase
        return result;
    endfunction

    // Sub-word store: replace only the addressed lane of the word just read.
    function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                                input logic [1:0] lane,
                                                input logic [31:0] word,
                                                input logic [31:0] wdata);
        logic [31:0] result;
        result = word;
        if (f3[1:0] == 2'b00) begin
            case (lane)
                2'd0:    result[7:0]   = wdata[7:0];
                2'd1:    result[15:8]  = wdata[7:0];
                2'd2:    result[23:16] = wdata[7:0];
                default: result[31:24] = wdata[7:0];
            endcase
        end else if (lane[1]) begin
            result[31:16] = wdata[15:0];
        end else begin
            result[15:0] = wdata[15:0];
        end
        return result;
    endfunction

    // Outputs are registered and take their value for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            store_q    <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            word_q     <= 32'd0;
            req_ready  <= 1'b1;
            resp_done  <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= 32'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_we     <= 1'b0;
        end else begin
            req_ready  <= 1'b0;
            resp_done  <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= 32'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_we     <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        store_q   <= req_store;
                        funct3_q  <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        if (is_fault(req_store, req_funct3, req_addr)) begin
                            state      <= ERR;
                            resp_done  <= 1'b1;
                            resp_fault <= 1'b1;
                        end else if (req_store && req_funct3 == 3'b010) begin
                            state     <= WR;
                            mem_we    <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= RD;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                RD: begin
                    word_q <= mem_rdata;
                    if (store_q) begin
                        state     <= WR;
                        mem_we    <= 1'b1;
                        mem_addr  <= {addr_q[31:2], 2'b00};
                        mem_wdata <= store_merge(funct3_q, addr_q[1:0], mem_rdata, wdata_q);
                    end else begin
                        state      <= RESP;
                        resp_done  <= 1'b1;
                        resp_rdata <= load_extend(funct3_q, addr_q[1:0], mem_rdata);
                    end
                end
                WR: begin
                    state     <= RESP;
                    resp_done <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
